// File: rtl/ro_worker_pkg.sv
// Shared types and constants for the ring-oscillator worker result path.
// Holds the FSM state encoding, default word width and a width helper.
package ro_worker_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFTING = 2'd1,
        DONE     = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ro_result_shifter_if.sv
// Result-path bus between the worker (master) and the serial shifter (slave).
// Carries the load request and the shifter's serial output and status.
interface ro_result_shifter_if
    import ro_worker_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    localparam int BW = clog2(WIDTH + 1);

    logic             load;
    logic [WIDTH-1:0] load_data;
    logic             lsb_first;
    logic             sdo;
    logic             busy;
    logic             done;
    logic [BW-1:0]    bits_left;

    modport master (
        output load, load_data, lsb_first,
        input  sdo, busy, done, bits_left
    );

    modport slave (
        input  load, load_data, lsb_first,
        output sdo, busy, done, bits_left
    );

endinterface

// File: rtl/sync_rise_detect.sv
// Multi-flop synchronizer with rising-edge detect for an asynchronous pad.
// All flops reset high so a pin held high through reset gives no edge.
module sync_rise_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic internal_clock,
    input  logic reset,
    input  logic async_in,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge internal_clock) begin
        if (reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ro_result_shifter.sv
// Captures a result word on load and shifts it out one bit per
// synchronized rising edge of the external shift pin.
module ro_result_shifter
    import ro_worker_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic internal_clock,
    input  logic reset,
    input  logic shift_pin,
    ro_result_shifter_if.slave bus
);

    localparam int BW = clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             order_q, order_d;
    logic [BW-1:0]    cnt_q, cnt_d;
    logic             rise;
    logic             shift_en;

    sync_rise_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .internal_clock(internal_clock),
        .reset         (reset),
        .async_in      (shift_pin),
        .rise          (rise)
    );

    always_ff @(posedge internal_clock) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            order_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            order_q <= order_d;
            cnt_q   <= cnt_d;
        end
    end

    assign shift_en = rise & (state_q == SHIFTING);

    // A load always wins over a coincident rise; the rise is dropped.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        order_d = order_q;
        cnt_d   = cnt_q;
        unique case (1'b1)
            bus.load: begin
                state_d = SHIFTING;
                shreg_d = bus.load_data;
                order_d = bus.lsb_first;
                cnt_d   = BW'(WIDTH);
            end
            (!bus.load && shift_en): begin
                shreg_d = order_q ? (shreg_q >> 1) : (shreg_q << 1);
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == BW'(1)) begin
                    state_d = DONE;
                end
            end
            default: begin
            end
        endcase
    end

    assign bus.busy      = (state_q == SHIFTING);
    assign bus.done      = (state_q == DONE);
    assign bus.bits_left = cnt_q;
    assign bus.sdo       = (state_q == SHIFTING)
                         & (order_q ? shreg_q[0] : shreg_q[WIDTH-1]);

endmodule

// File: tb/tb_ro_result_shifter.sv
// Directed bench for ro_result_shifter: serial order, counter, done timing,
// restart, load/rise collision and reset mid-transfer.
module tb_ro_result_shifter;

    logic internal_clock = 1'b0;
    logic reset          = 1'b1;
    logic shift_pin      = 1'b1;

    int checks = 0;
    int errors = 0;

    ro_result_shifter_if #(.WIDTH(16)) bus ();

    ro_result_shifter #(
        .WIDTH      (16),
        .SYNC_STAGES(2)
    ) dut (
        .internal_clock(internal_clock),
        .reset         (reset),
        .shift_pin     (shift_pin),
        .bus           (bus)
    );

    always #5 internal_clock = ~internal_clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse();
        shift_pin = 1'b1;
        repeat (4) @(negedge internal_clock);
        shift_pin = 1'b0;
        repeat (4) @(negedge internal_clock);
    endtask

    task automatic do_load(input logic [15:0] d, input logic lsb);
        bus.load      = 1'b1;
        bus.load_data = d;
        bus.lsb_first = lsb;
        @(negedge internal_clock);
        bus.load      = 1'b0;
    endtask

    logic [15:0] w;
    logic [15:0] seq_msb;
    logic [15:0] seq_lsb;

    initial begin
        bus.load      = 1'b0;
        bus.load_data = '0;
        bus.lsb_first = 1'b0;
        seq_msb = 16'b1010_0101_1100_0011;
        seq_lsb = 16'b1100_0011_1010_0101;

        // 1: reset with pin high, then idle
        repeat (3) @(negedge internal_clock);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge internal_clock);
            chk("t1_busy", bus.busy, 0);
            chk("t1_done", bus.done, 0);
            chk("t1_sdo", bus.sdo, 0);
            chk("t1_bits", bus.bits_left, 0);
        end
        shift_pin = 1'b0;
        repeat (4) @(negedge internal_clock);

        // 2: MSB-first 0xA5C3
        do_load(16'hA5C3, 1'b0);
        chk("t2_bits_init", bus.bits_left, 16);
        chk("t2_busy", bus.busy, 1);
        for (int i = 0; i < 16; i++) begin
            chk("t2_sdo", bus.sdo, seq_msb[15-i]);
            if (i == 15) begin
                shift_pin = 1'b1;
                repeat (2) @(negedge internal_clock);
                chk("t2_done_early", bus.done, 0);
                @(negedge internal_clock);
                chk("t2_done_3cyc", bus.done, 1);
                @(negedge internal_clock);
                shift_pin = 1'b0;
                repeat (4) @(negedge internal_clock);
            end else begin
                pulse();
            end
            chk("t2_bits", bus.bits_left, 15 - i);
        end
        chk("t2_busy_end", bus.busy, 0);

        // 3: LSB-first 0xA5C3, then extra pulses in DONE
        do_load(16'hA5C3, 1'b1);
        chk("t3_done_clr", bus.done, 0);
        bus.lsb_first = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chk("t3_sdo", bus.sdo, seq_lsb[15-i]);
            pulse();
        end
        chk("t3_done", bus.done, 1);
        for (int i = 0; i < 3; i++) begin
            pulse();
            chk("t3_extra_done", bus.done, 1);
            chk("t3_extra_sdo", bus.sdo, 0);
            chk("t3_extra_bits", bus.bits_left, 0);
        end

        // 4: restart mid-transfer
        do_load(16'hFFFF, 1'b0);
        repeat (5) pulse();
        chk("t4_bits5", bus.bits_left, 11);
        chk("t4_sdo_ff", bus.sdo, 1);
        do_load(16'h0001, 1'b0);
        chk("t4_bits_restart", bus.bits_left, 16);
        for (int i = 0; i < 15; i++) begin
            chk("t4_sdo_zero", bus.sdo, 0);
            pulse();
        end
        chk("t4_sdo_last", bus.sdo, 1);
        chk("t4_bits_last", bus.bits_left, 1);
        chk("t4_not_done", bus.done, 0);
        pulse();
        chk("t4_done", bus.done, 1);

        // 5: load coincides with a detected rise
        do_load(16'hFFFF, 1'b0);
        repeat (2) pulse();
        chk("t5_bits_pre", bus.bits_left, 14);
        shift_pin = 1'b1;
        repeat (2) @(negedge internal_clock);
        w = 16'h8000;
        do_load(w, 1'b0);
        chk("t5_bits", bus.bits_left, 16);
        chk("t5_sdo", bus.sdo, 1);
        @(negedge internal_clock);
        chk("t5_bits_hold", bus.bits_left, 16);
        shift_pin = 1'b0;
        repeat (4) @(negedge internal_clock);
        pulse();
        chk("t5_bits_next", bus.bits_left, 15);
        chk("t5_sdo_next", bus.sdo, 0);

        // 6: reset mid-transfer
        do_load(16'hA5C3, 1'b0);
        repeat (8) pulse();
        chk("t6_bits8", bus.bits_left, 8);
        chk("t6_busy8", bus.busy, 1);
        reset = 1'b1;
        @(negedge internal_clock);
        reset = 1'b0;
        chk("t6_busy", bus.busy, 0);
        chk("t6_done", bus.done, 0);
        chk("t6_bits", bus.bits_left, 0);
        chk("t6_sdo", bus.sdo, 0);
        repeat (3) pulse();
        chk("t6_ign_busy", bus.busy, 0);
        chk("t6_ign_done", bus.done, 0);
        chk("t6_ign_bits", bus.bits_left, 0);
        do_load(16'h0F00, 1'b0);
        chk("t6_reload_bits", bus.bits_left, 16);
        chk("t6_reload_sdo", bus.sdo, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
